// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared constants for the MIPS decode slice: opcode and funct
//   encodings, ALU operation codes, memory access sizes and the packed
//   layout of the ID/EX control word.
//   Control word bit order, MSB first:
//     [11] reg_write  [10] mem_read  [9] mem_write  [8] mem_to_reg
//     [7]  alu_src    [6]  link      [5:2] alu_op   [1:0] mem_size
package mips_pkg;

   localparam int NB_ADDR = 5;
   localparam int NB_CTRL = 12;

   localparam logic [NB_ADDR-1:0] REG_RA = 5'd31;

   typedef enum logic [5:0] {
      OP_SPECIAL = 6'h00,
      OP_J       = 6'h02,
      OP_JAL     = 6'h03,
      OP_BEQ     = 6'h04,
      OP_BNE     = 6'h05,
      OP_ADDIU   = 6'h09,
      OP_SLTI    = 6'h0A,
      OP_ANDI    = 6'h0C,
      OP_ORI     = 6'h0D,
      OP_XORI    = 6'h0E,
      OP_LUI     = 6'h0F,
      OP_LB      = 6'h20,
      OP_LH      = 6'h21,
      OP_LW      = 6'h23,
      OP_LBU     = 6'h24,
      OP_LHU     = 6'h25,
      OP_SB      = 6'h28,
      OP_SH      = 6'h29,
      OP_SW      = 6'h2B
   } opcode_e;

   typedef enum logic [5:0] {
      FN_SLL  = 6'h00,
      FN_SRL  = 6'h02,
      FN_SRA  = 6'h03,
      FN_SLLV = 6'h04,
      FN_SRLV = 6'h06,
      FN_SRAV = 6'h07,
      FN_JR   = 6'h08,
      FN_JALR = 6'h09,
      FN_ADDU = 6'h21,
      FN_SUBU = 6'h23,
      FN_AND  = 6'h24,
      FN_OR   = 6'h25,
      FN_XOR  = 6'h26,
      FN_NOR  = 6'h27,
      FN_SLT  = 6'h2A
   } funct_e;

   // ALU_ADD_LDU is the address add of an unsigned load; it tells MEM to
   // zero-extend the loaded byte/half instead of sign-extending it.
   typedef enum logic [3:0] {
      ALU_NONE    = 4'd0,
      ALU_ADD     = 4'd1,
      ALU_SUB     = 4'd2,
      ALU_AND     = 4'd3,
      ALU_OR      = 4'd4,
      ALU_XOR     = 4'd5,
      ALU_NOR     = 4'd6,
      ALU_SLT     = 4'd7,
      ALU_SLL     = 4'd8,
      ALU_SRL     = 4'd9,
      ALU_SRA     = 4'd10,
      ALU_SLLV    = 4'd11,
      ALU_SRLV    = 4'd12,
      ALU_SRAV    = 4'd13,
      ALU_LUI     = 4'd14,
      ALU_ADD_LDU = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_e;

   typedef struct packed {
      logic      reg_write;
      logic      mem_read;
      logic      mem_write;
      logic      mem_to_reg;
      logic      alu_src;
      logic      link;
      alu_op_e   alu_op;
      mem_size_e mem_size;
   } ctrl_t;

endpackage

// File: rtl/register_file.sv
// register_file
//   General purpose register file: two asynchronous read ports, one
//   synchronous write port. Register 0 always reads as zero and ignores
//   writes. Synchronous reset clears every entry in one cycle.
//   Optional macro ID_WB_BYPASS_EN: a read port whose address matches a
//   non-zero write address while i_we=1 returns i_wr_data directly.
// Ports
//   i_clock, i_reset            clock, synchronous active-high reset
//   i_valid                     write is committed only when set
//   i_we, i_wr_addr, i_wr_data  write port
//   i_rd_addr_a/b, o_rd_data_a/b  read ports
module register_file
   import mips_pkg::*;
#(
   parameter int NB_REG = 32,
   parameter int N_REGS = 32
)(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_valid,
   input  logic              i_we,
   input  logic [NB_ADDR-1:0] i_wr_addr,
   input  logic [NB_REG-1:0] i_wr_data,
   input  logic [NB_ADDR-1:0] i_rd_addr_a,
   input  logic [NB_ADDR-1:0] i_rd_addr_b,
   output logic [NB_REG-1:0] o_rd_data_a,
   output logic [NB_REG-1:0] o_rd_data_b
);

   logic [NB_REG-1:0] regs [N_REGS];

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         regs <= '{default: '0};
      end else if (i_valid && i_we && (i_wr_addr != '0)) begin
         regs[i_wr_addr] <= i_wr_data;
      end
   end

   always_comb begin
      o_rd_data_a = (i_rd_addr_a == '0) ? '0 : regs[i_rd_addr_a];
      o_rd_data_b = (i_rd_addr_b == '0) ? '0 : regs[i_rd_addr_b];
`ifdef ID_WB_BYPASS_EN
      if (i_we && (i_wr_addr != '0) && (i_wr_addr == i_rd_addr_a)) begin
         o_rd_data_a = i_wr_data;
      end
      if (i_we && (i_wr_addr != '0) && (i_wr_addr == i_rd_addr_b)) begin
         o_rd_data_b = i_wr_data;
      end
`endif
   end

endmodule

// File: rtl/instruction_decode.sv
// instruction_decode
//   MIPS ID stage: register file access, instruction decode, load-use and
//   ID-resolved branch hazard detection, branch/jump resolution and the
//   ID/EX pipeline register.
//   Optional macro ID_WB_BYPASS_EN: same-cycle writeback write-through to
//   the register read ports (and thus to o_rs and the branch compare).
// Ports
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_valid                   pipeline advance enable
//   i_instr, i_pc             instruction and pc+4 from fetch
//   i_wb_we/addr/data         writeback port
//   i_ex_mem_read, i_ex_reg_write, i_ex_wr_addr   EX-stage hazard info
//   o_inm_i, o_inm_j, o_rs, o_jump_inm, o_jump_rs, o_branch, o_hazard
//                             combinational, to fetch
//   o_rs_data ... o_ctrl      registered ID/EX outputs
module instruction_decode
   import mips_pkg::*;
#(
   parameter int NB_REG   = 32,
   parameter int NB_INSTR = 32,
   parameter int N_REGS   = 32
)(
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_valid,
   input  logic [NB_INSTR-1:0] i_instr,
   input  logic [NB_REG-1:0]   i_pc,
   input  logic                i_wb_we,
   input  logic [NB_ADDR-1:0]  i_wb_addr,
   input  logic [NB_REG-1:0]   i_wb_data,
   input  logic                i_ex_mem_read,
   input  logic                i_ex_reg_write,
   input  logic [NB_ADDR-1:0]  i_ex_wr_addr,
   output logic [15:0]         o_inm_i,
   output logic [25:0]         o_inm_j,
   output logic [NB_REG-1:0]   o_rs,
   output logic                o_jump_inm,
   output logic                o_jump_rs,
   output logic                o_branch,
   output logic                o_hazard,
   output logic [NB_REG-1:0]   o_rs_data,
   output logic [NB_REG-1:0]   o_rt_data,
   output logic [NB_REG-1:0]   o_inm_ext,
   output logic [NB_REG-1:0]   o_pc,
   output logic [NB_ADDR-1:0]  o_rs_addr,
   output logic [NB_ADDR-1:0]  o_rt_addr,
   output logic [NB_ADDR-1:0]  o_wr_addr,
   output logic [NB_CTRL-1:0]  o_ctrl
);

   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic [NB_ADDR-1:0] rs_addr;
   logic [NB_ADDR-1:0] rt_addr;
   logic [NB_ADDR-1:0] rd_addr;
   logic [NB_REG-1:0]  rs_data;
   logic [NB_REG-1:0]  rt_data;
   logic [NB_REG-1:0]  inm_ext;

   ctrl_t              dec_ctrl;
   logic [NB_ADDR-1:0] dec_wr_addr;
   logic               uses_rs;
   logic               uses_rt;
   logic               zero_ext;
   logic               is_beq;
   logic               is_bne;
   logic               is_jump_inm;
   logic               is_jump_rs;
   logic               src_hit;

   assign opcode  = i_instr[31:26];
   assign funct   = i_instr[5:0];
   assign rs_addr = i_instr[25:21];
   assign rt_addr = i_instr[20:16];
   assign rd_addr = i_instr[15:11];

   register_file #(
      .NB_REG (NB_REG),
      .N_REGS (N_REGS)
   ) u_register_file (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_valid     (i_valid),
      .i_we        (i_wb_we),
      .i_wr_addr   (i_wb_addr),
      .i_wr_data   (i_wb_data),
      .i_rd_addr_a (rs_addr),
      .i_rd_addr_b (rt_addr),
      .o_rd_data_a (rs_data),
      .o_rd_data_b (rt_data)
   );

   assign o_inm_i = i_instr[15:0];
   assign o_inm_j = i_instr[25:0];
   assign o_rs    = rs_data;

   assign inm_ext = zero_ext ? {{(NB_REG-16){1'b0}}, i_instr[15:0]}
                             : {{(NB_REG-16){i_instr[15]}}, i_instr[15:0]};

   // Decode is suppressed during reset so the instruction behaves as a NOP
   // and no hazard, branch or jump can be signalled to fetch.
   always_comb begin
      dec_ctrl    = '0;
      dec_wr_addr = '0;
      uses_rs     = 1'b0;
      uses_rt     = 1'b0;
      zero_ext    = 1'b0;
      is_beq      = 1'b0;
      is_bne      = 1'b0;
      is_jump_inm = 1'b0;
      is_jump_rs  = 1'b0;
      if (!i_reset) begin
         case (opcode)
            OP_SPECIAL: begin
               dec_wr_addr        = rd_addr;
               dec_ctrl.reg_write = 1'b1;
               uses_rs            = 1'b1;
               uses_rt            = 1'b1;
               case (funct)
                  FN_SLL:  begin dec_ctrl.alu_op = ALU_SLL;  uses_rs = 1'b0; end
                  FN_SRL:  begin dec_ctrl.alu_op = ALU_SRL;  uses_rs = 1'b0; end
                  FN_SRA:  begin dec_ctrl.alu_op = ALU_SRA;  uses_rs = 1'b0; end
                  FN_SLLV: dec_ctrl.alu_op = ALU_SLLV;
                  FN_SRLV: dec_ctrl.alu_op = ALU_SRLV;
                  FN_SRAV: dec_ctrl.alu_op = ALU_SRAV;
                  FN_ADDU: dec_ctrl.alu_op = ALU_ADD;
                  FN_SUBU: dec_ctrl.alu_op = ALU_SUB;
                  FN_AND:  dec_ctrl.alu_op = ALU_AND;
                  FN_OR:   dec_ctrl.alu_op = ALU_OR;
                  FN_XOR:  dec_ctrl.alu_op = ALU_XOR;
                  FN_NOR:  dec_ctrl.alu_op = ALU_NOR;
                  FN_SLT:  dec_ctrl.alu_op = ALU_SLT;
                  FN_JR: begin
                     dec_ctrl    = '0;
                     dec_wr_addr = '0;
                     uses_rt     = 1'b0;
                     is_jump_rs  = 1'b1;
                  end
                  FN_JALR: begin
                     // Link value is pc+4, carried to EX on o_pc.
                     dec_ctrl.alu_op = ALU_ADD;
                     dec_ctrl.link   = 1'b1;
                     uses_rt         = 1'b0;
                     is_jump_rs      = 1'b1;
                  end
                  default: begin
                     dec_ctrl    = '0;
                     dec_wr_addr = '0;
                     uses_rs     = 1'b0;
                     uses_rt     = 1'b0;
                  end
               endcase
            end
            OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
               dec_wr_addr        = rt_addr;
               dec_ctrl.reg_write = 1'b1;
               dec_ctrl.alu_src   = 1'b1;
               uses_rs            = 1'b1;
               case (opcode)
                  OP_ADDIU: dec_ctrl.alu_op = ALU_ADD;
                  OP_SLTI:  dec_ctrl.alu_op = ALU_SLT;
                  OP_ANDI:  begin dec_ctrl.alu_op = ALU_AND; zero_ext = 1'b1; end
                  OP_ORI:   begin dec_ctrl.alu_op = ALU_OR;  zero_ext = 1'b1; end
                  default:  begin dec_ctrl.alu_op = ALU_XOR; zero_ext = 1'b1; end
               endcase
            end
            OP_LUI: begin
               dec_wr_addr        = rt_addr;
               dec_ctrl.reg_write = 1'b1;
               dec_ctrl.alu_src   = 1'b1;
               dec_ctrl.alu_op    = ALU_LUI;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
               dec_wr_addr         = rt_addr;
               dec_ctrl.reg_write  = 1'b1;
               dec_ctrl.mem_read   = 1'b1;
               dec_ctrl.mem_to_reg = 1'b1;
               dec_ctrl.alu_src    = 1'b1;
               dec_ctrl.alu_op     = ALU_ADD;
               uses_rs             = 1'b1;
               case (opcode)
                  OP_LB:   dec_ctrl.mem_size = MEM_BYTE;
                  OP_LH:   dec_ctrl.mem_size = MEM_HALF;
                  OP_LBU:  begin dec_ctrl.mem_size = MEM_BYTE; dec_ctrl.alu_op = ALU_ADD_LDU; end
                  OP_LHU:  begin dec_ctrl.mem_size = MEM_HALF; dec_ctrl.alu_op = ALU_ADD_LDU; end
                  default: dec_ctrl.mem_size = MEM_WORD;
               endcase
            end
            OP_SB, OP_SH, OP_SW: begin
               dec_ctrl.mem_write = 1'b1;
               dec_ctrl.alu_src   = 1'b1;
               dec_ctrl.alu_op    = ALU_ADD;
               uses_rs            = 1'b1;
               uses_rt            = 1'b1;
               case (opcode)
                  OP_SB:   dec_ctrl.mem_size = MEM_BYTE;
                  OP_SH:   dec_ctrl.mem_size = MEM_HALF;
                  default: dec_ctrl.mem_size = MEM_WORD;
               endcase
            end
            OP_BEQ: begin
               uses_rs = 1'b1;
               uses_rt = 1'b1;
               is_beq  = 1'b1;
            end
            OP_BNE: begin
               uses_rs = 1'b1;
               uses_rt = 1'b1;
               is_bne  = 1'b1;
            end
            OP_J: begin
               is_jump_inm = 1'b1;
            end
            OP_JAL: begin
               dec_wr_addr        = REG_RA;
               dec_ctrl.reg_write = 1'b1;
               dec_ctrl.link      = 1'b1;
               dec_ctrl.alu_op    = ALU_ADD;
               is_jump_inm        = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // A load in EX stalls any consumer; a plain ALU result in EX only stalls
   // instructions that need their operands already in ID (branches, JR/JALR).
   always_comb begin
      src_hit = (i_ex_wr_addr != '0) &&
                ((uses_rs && (rs_addr == i_ex_wr_addr)) ||
                 (uses_rt && (rt_addr == i_ex_wr_addr)));
      o_hazard = src_hit &&
                 (i_ex_mem_read ||
                  (i_ex_reg_write && (is_beq || is_bne || is_jump_rs)));
      o_branch   = !o_hazard &&
                   ((is_beq && (rs_data == rt_data)) ||
                    (is_bne && (rs_data != rt_data)));
      o_jump_inm = !o_hazard && is_jump_inm;
      o_jump_rs  = !o_hazard && is_jump_rs;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_rs_data <= '0;
         o_rt_data <= '0;
         o_inm_ext <= '0;
         o_pc      <= '0;
         o_rs_addr <= '0;
         o_rt_addr <= '0;
         o_wr_addr <= '0;
         o_ctrl    <= '0;
      end else if (i_valid) begin
         o_rs_data <= rs_data;
         o_rt_data <= rt_data;
         o_inm_ext <= inm_ext;
         o_pc      <= i_pc;
         o_rs_addr <= rs_addr;
         o_rt_addr <= rt_addr;
         if (o_hazard) begin
            o_ctrl    <= '0;
            o_wr_addr <= '0;
         end else begin
            o_ctrl    <= dec_ctrl;
            o_wr_addr <= dec_wr_addr;
         end
      end
   end

endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode
//   Scoreboard bench for instruction_decode. Expected values are queued
//   when stimulus is driven; combinational ones are popped just after the
//   inputs settle, registered ones just after the following rising edge.
//   Honours ID_WB_BYPASS_EN for the same-cycle writeback read case.
module tb_instruction_decode;
   import mips_pkg::*;

   localparam int NB_REG = 32;

   logic               i_clock;
   logic               i_reset;
   logic               i_valid;
   logic [31:0]        i_instr;
   logic [NB_REG-1:0]  i_pc;
   logic               i_wb_we;
   logic [4:0]         i_wb_addr;
   logic [NB_REG-1:0]  i_wb_data;
   logic               i_ex_mem_read;
   logic               i_ex_reg_write;
   logic [4:0]         i_ex_wr_addr;
   logic [15:0]        o_inm_i;
   logic [25:0]        o_inm_j;
   logic [NB_REG-1:0]  o_rs;
   logic               o_jump_inm;
   logic               o_jump_rs;
   logic               o_branch;
   logic               o_hazard;
   logic [NB_REG-1:0]  o_rs_data;
   logic [NB_REG-1:0]  o_rt_data;
   logic [NB_REG-1:0]  o_inm_ext;
   logic [NB_REG-1:0]  o_pc;
   logic [4:0]         o_rs_addr;
   logic [4:0]         o_rt_addr;
   logic [4:0]         o_wr_addr;
   logic [NB_CTRL-1:0] o_ctrl;

   instruction_decode #(
      .NB_REG   (NB_REG),
      .NB_INSTR (32),
      .N_REGS   (32)
   ) dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_valid        (i_valid),
      .i_instr        (i_instr),
      .i_pc           (i_pc),
      .i_wb_we        (i_wb_we),
      .i_wb_addr      (i_wb_addr),
      .i_wb_data      (i_wb_data),
      .i_ex_mem_read  (i_ex_mem_read),
      .i_ex_reg_write (i_ex_reg_write),
      .i_ex_wr_addr   (i_ex_wr_addr),
      .o_inm_i        (o_inm_i),
      .o_inm_j        (o_inm_j),
      .o_rs           (o_rs),
      .o_jump_inm     (o_jump_inm),
      .o_jump_rs      (o_jump_rs),
      .o_branch       (o_branch),
      .o_hazard       (o_hazard),
      .o_rs_data      (o_rs_data),
      .o_rt_data      (o_rt_data),
      .o_inm_ext      (o_inm_ext),
      .o_pc           (o_pc),
      .o_rs_addr      (o_rs_addr),
      .o_rt_addr      (o_rt_addr),
      .o_wr_addr      (o_wr_addr),
      .o_ctrl         (o_ctrl)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   typedef enum int {
      S_RS_DATA, S_RT_DATA, S_INM_EXT, S_PC, S_RS_ADDR, S_RT_ADDR,
      S_WR_ADDR, S_CTRL, S_INM_I, S_INM_J, S_RS, S_JINM, S_JRS,
      S_BRANCH, S_HAZARD
   } sel_e;

   typedef struct {
      string       tag;
      sel_e        sel;
      logic [31:0] exp;
   } exp_t;

   exp_t        comb_q[$];
   exp_t        reg_q[$];
   int          n_compared   = 0;
   int          n_mismatched = 0;
   logic [31:0] pc_ctr       = 32'h0000_1000;
   logic [31:0] cur_pc;
   logic [31:0] bypass_exp;

   function automatic logic [31:0] observe(input sel_e s);
      case (s)
         S_RS_DATA: return o_rs_data;
         S_RT_DATA: return o_rt_data;
         S_INM_EXT: return o_inm_ext;
         S_PC:      return o_pc;
         S_RS_ADDR: return {27'd0, o_rs_addr};
         S_RT_ADDR: return {27'd0, o_rt_addr};
         S_WR_ADDR: return {27'd0, o_wr_addr};
         S_CTRL:    return {20'd0, o_ctrl};
         S_INM_I:   return {16'd0, o_inm_i};
         S_INM_J:   return {6'd0, o_inm_j};
         S_RS:      return o_rs;
         S_JINM:    return {31'd0, o_jump_inm};
         S_JRS:     return {31'd0, o_jump_rs};
         S_BRANCH:  return {31'd0, o_branch};
         default:   return {31'd0, o_hazard};
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {6'd0, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
      return {op, tgt};
   endfunction

   function automatic logic [31:0] mk_ctrl(input logic rw, input logic mr, input logic mw,
                                           input logic m2r, input logic asrc, input logic lnk,
                                           input logic [3:0] alu, input logic [1:0] sz);
      return {20'd0, rw, mr, mw, m2r, asrc, lnk, alu, sz};
   endfunction

   task automatic exp_c(input string tag, input sel_e s, input logic [31:0] v);
      comb_q.push_back('{tag, s, v});
   endtask

   task automatic exp_r(input string tag, input sel_e s, input logic [31:0] v);
      reg_q.push_back('{tag, s, v});
   endtask

   task automatic defaults();
      i_reset        = 1'b0;
      i_valid        = 1'b1;
      i_wb_we        = 1'b0;
      i_wb_addr      = 5'd0;
      i_wb_data      = '0;
      i_ex_mem_read  = 1'b0;
      i_ex_reg_write = 1'b0;
      i_ex_wr_addr   = 5'd0;
   endtask

   task automatic drive(input logic [31:0] ins);
      i_instr = ins;
      i_pc    = pc_ctr;
      cur_pc  = pc_ctr;
      pc_ctr  = pc_ctr + 32'd4;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      i_wb_we   = 1'b1;
      i_wb_addr = a;
      i_wb_data = d;
   endtask

   // Called with inputs freshly driven on the falling edge.
   task automatic tick();
      exp_t e;
      #2;
      while (comb_q.size() > 0) begin
         e = comb_q.pop_front();
         check_eq(e.tag, observe(e.sel), e.exp);
      end
      @(posedge i_clock);
      #1;
      while (reg_q.size() > 0) begin
         e = reg_q.pop_front();
         check_eq(e.tag, observe(e.sel), e.exp);
      end
      @(negedge i_clock);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [4:0]  wa [5];
      logic [31:0] wd [5];
      wa = '{5'd5, 5'd1, 5'd2, 5'd0, 5'd4};
      wd = '{32'h1234, 32'd7, 32'd7, 32'hFF, 32'h11};

      // Reset: hazard/branch suppressed, writeback ignored, regs cleared.
      defaults();
      i_reset       = 1'b1;
      i_ex_mem_read = 1'b1;
      i_ex_wr_addr  = 5'd1;
      wb(5'd9, 32'h55);
      drive(enc_i(OP_BEQ, 5'd1, 5'd1, 16'd4));
      exp_c("rst_hazard", S_HAZARD, 0);
      exp_c("rst_branch", S_BRANCH, 0);
      exp_r("rst_ctrl", S_CTRL, 0);
      exp_r("rst_wr", S_WR_ADDR, 0);
      exp_r("rst_pc", S_PC, 0);
      exp_r("rst_inm", S_INM_EXT, 0);
      tick();

      for (int i = 0; i < 5; i++) begin
         defaults();
         wb(wa[i], wd[i]);
         drive(32'd0);
         tick();
      end

      defaults();
      drive(enc_i(OP_ADDIU, 5'd5, 5'd6, 16'hFFFF));
      exp_c("addiu_rs", S_RS, 32'h1234);
      exp_c("addiu_inm_i", S_INM_I, 32'hFFFF);
      exp_c("addiu_hazard", S_HAZARD, 0);
      exp_r("addiu_rs_data", S_RS_DATA, 32'h1234);
      exp_r("addiu_inm_ext", S_INM_EXT, 32'hFFFF_FFFF);
      exp_r("addiu_wr", S_WR_ADDR, 6);
      exp_r("addiu_rs_addr", S_RS_ADDR, 5);
      exp_r("addiu_rt_addr", S_RT_ADDR, 6);
      exp_r("addiu_ctrl", S_CTRL, mk_ctrl(1, 0, 0, 0, 1, 0, ALU_ADD, 2'b00));
      exp_r("addiu_pc", S_PC, cur_pc);
      tick();

      defaults();
      drive(enc_i(OP_ANDI, 5'd5, 5'd7, 16'h8001));
      exp_r("andi_inm_ext", S_INM_EXT, 32'h0000_8001);
      exp_r("andi_wr", S_WR_ADDR, 7);
      exp_r("andi_ctrl", S_CTRL, mk_ctrl(1, 0, 0, 0, 1, 0, ALU_AND, 2'b00));
      tick();

      defaults();
      drive(enc_i(OP_LW, 5'd5, 5'd9, 16'h0008));
      exp_r("lw_ctrl", S_CTRL, mk_ctrl(1, 1, 0, 1, 1, 0, ALU_ADD, MEM_WORD));
      exp_r("lw_wr", S_WR_ADDR, 9);
      exp_r("lw_inm_ext", S_INM_EXT, 8);
      exp_r("lw_rs_data", S_RS_DATA, 32'h1234);
      tick();

      // Stall: ID/EX holds the LW and the writeback is not committed.
      defaults();
      i_valid = 1'b0;
      wb(5'd10, 32'h77);
      drive(enc_i(OP_ADDIU, 5'd1, 5'd11, 16'd5));
      exp_r("hold_wr", S_WR_ADDR, 9);
      exp_r("hold_ctrl", S_CTRL, mk_ctrl(1, 1, 0, 1, 1, 0, ALU_ADD, MEM_WORD));
      exp_r("hold_inm_ext", S_INM_EXT, 8);
      exp_r("hold_pc", S_PC, cur_pc - 32'd4);
      tick();

      defaults();
      drive(enc_r(FN_ADDU, 5'd10, 5'd9, 5'd8));
      exp_r("nowrite_r10", S_RS_DATA, 0);
      exp_r("rstwb_r9", S_RT_DATA, 0);
      exp_r("addu_wr", S_WR_ADDR, 8);
      exp_r("addu_ctrl", S_CTRL, mk_ctrl(1, 0, 0, 0, 0, 0, ALU_ADD, 2'b00));
      tick();

      // Load-use hazards.
      defaults();
      i_ex_mem_read = 1'b1;
      i_ex_wr_addr  = 5'd2;
      drive(enc_r(FN_ADDU, 5'd2, 5'd1, 5'd3));
      exp_c("lu_rs_hazard", S_HAZARD, 1);
      exp_r("lu_bubble_ctrl", S_CTRL, 0);
      exp_r("lu_bubble_wr", S_WR_ADDR, 0);
      tick();

      defaults();
      i_ex_mem_read = 1'b1;
      i_ex_wr_addr  = 5'd2;
      drive(enc_r(FN_ADDU, 5'd1, 5'd2, 5'd3));
      exp_c("lu_rt_hazard", S_HAZARD, 1);
      exp_r("lu_rt_bubble", S_CTRL, 0);
      tick();

      defaults();
      i_ex_mem_read = 1'b1;
      i_ex_wr_addr  = 5'd0;
      drive(enc_r(FN_ADDU, 5'd0, 5'd1, 5'd3));
      exp_c("lu_r0_nohazard", S_HAZARD, 0);
      exp_r("lu_r0_wr", S_WR_ADDR, 3);
      tick();

      defaults();
      i_ex_mem_read = 1'b1;
      i_ex_wr_addr  = 5'd2;
      drive(enc_i(OP_LUI, 5'd2, 5'd3, 16'h1234));
      exp_c("lui_nohazard", S_HAZARD, 0);
      exp_r("lui_ctrl", S_CTRL, mk_ctrl(1, 0, 0, 0, 1, 0, ALU_LUI, 2'b00));
      tick();

      // Branches resolved in ID.
      defaults();
      drive(enc_i(OP_BEQ, 5'd1, 5'd2, 16'd4));
      exp_c("beq_taken", S_BRANCH, 1);
      exp_c("beq_inm_i", S_INM_I, 4);
      exp_c("beq_jinm", S_JINM, 0);
      exp_c("beq_jrs", S_JRS, 0);
      exp_r("beq_wr", S_WR_ADDR, 0);
      tick();

      defaults();
      drive(enc_i(OP_BNE, 5'd1, 5'd2, 16'd4));
      exp_c("bne_not_taken", S_BRANCH, 0);
      tick();

      defaults();
      drive(enc_i(OP_BNE, 5'd1, 5'd5, 16'd8));
      exp_c("bne_taken", S_BRANCH, 1);
      tick();

      defaults();
      i_ex_reg_write = 1'b1;
      i_ex_wr_addr   = 5'd1;
      drive(enc_i(OP_BEQ, 5'd1, 5'd2, 16'd4));
      exp_c("beq_ex_hazard", S_HAZARD, 1);
      exp_c("beq_hazard_nobr", S_BRANCH, 0);
      tick();

      defaults();
      i_ex_reg_write = 1'b1;
      i_ex_wr_addr   = 5'd1;
      drive(enc_r(FN_ADDU, 5'd1, 5'd2, 5'd3));
      exp_c("alu_ex_nohazard", S_HAZARD, 0);
      tick();

      defaults();
      drive(enc_r(FN_JR, 5'd5, 5'd0, 5'd0));
      exp_c("jr_jrs", S_JRS, 1);
      exp_c("jr_rs", S_RS, 32'h1234);
      exp_c("jr_branch", S_BRANCH, 0);
      exp_c("jr_jinm", S_JINM, 0);
      tick();

      defaults();
      drive(enc_r(FN_JALR, 5'd5, 5'd0, 5'd31));
      exp_c("jalr_jrs", S_JRS, 1);
      exp_r("jalr_wr", S_WR_ADDR, 31);
      exp_r("jalr_ctrl", S_CTRL, mk_ctrl(1, 0, 0, 0, 0, 1, ALU_ADD, 2'b00));
      tick();

      defaults();
      drive(enc_r(FN_ADDU, 5'd0, 5'd0, 5'd8));
      exp_c("r0_rs", S_RS, 0);
      exp_r("r0_rs_data", S_RS_DATA, 0);
      exp_r("r0_rt_data", S_RT_DATA, 0);
      tick();

      defaults();
      drive(enc_j(OP_JAL, 26'h100));
      exp_c("jal_jinm", S_JINM, 1);
      exp_c("jal_inm_j", S_INM_J, 32'h100);
      exp_c("jal_jrs", S_JRS, 0);
      exp_r("jal_wr", S_WR_ADDR, 31);
      exp_r("jal_ctrl", S_CTRL, mk_ctrl(1, 0, 0, 0, 0, 1, ALU_ADD, 2'b00));
      tick();

      defaults();
      drive({6'h3F, 5'd5, 5'd6, 16'h0001});
      exp_r("unknown_ctrl", S_CTRL, 0);
      exp_r("unknown_wr", S_WR_ADDR, 0);
      tick();

      // Writeback to r4 in the same cycle r4 is read.
`ifdef ID_WB_BYPASS_EN
      bypass_exp = 32'hAA;
`else
      bypass_exp = 32'h11;
`endif
      defaults();
      wb(5'd4, 32'hAA);
      drive(enc_r(FN_ADDU, 5'd4, 5'd0, 5'd8));
      exp_c("wb_same_rs", S_RS, bypass_exp);
      exp_r("wb_same_rs_data", S_RS_DATA, bypass_exp);
      tick();

      defaults();
      drive(enc_r(FN_ADDU, 5'd4, 5'd0, 5'd8));
      exp_r("wb_after_rs_data", S_RS_DATA, 32'hAA);
      tick();

      defaults();
      drive(enc_i(OP_SW, 5'd5, 5'd4, 16'h0004));
      exp_r("sw_ctrl", S_CTRL, mk_ctrl(0, 0, 1, 0, 1, 0, ALU_ADD, MEM_WORD));
      exp_r("sw_wr", S_WR_ADDR, 0);
      exp_r("sw_rt_data", S_RT_DATA, 32'hAA);
      tick();

      // Reset mid-stream.
      defaults();
      i_reset = 1'b1;
      drive(enc_i(OP_ADDIU, 5'd5, 5'd6, 16'hFFFF));
      exp_r("mrst_rs_data", S_RS_DATA, 0);
      exp_r("mrst_rt_data", S_RT_DATA, 0);
      exp_r("mrst_inm_ext", S_INM_EXT, 0);
      exp_r("mrst_pc", S_PC, 0);
      exp_r("mrst_rs_addr", S_RS_ADDR, 0);
      exp_r("mrst_rt_addr", S_RT_ADDR, 0);
      exp_r("mrst_wr", S_WR_ADDR, 0);
      exp_r("mrst_ctrl", S_CTRL, 0);
      tick();

      defaults();
      drive(enc_r(FN_ADDU, 5'd5, 5'd4, 5'd8));
      exp_r("mrst_r5_cleared", S_RS_DATA, 0);
      exp_r("mrst_r4_cleared", S_RT_DATA, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
